// File: rtl/set_clear_flags.sv
// set_clear_flags
// Sticky event flag bank. Every channel has a flag that is set by any of its
// source bits and cleared by its clear strobe. Each channel also has a sticky
// overflow flag and a saturating count of set events. A masked OR of all the
// flags gives a registered interrupt line.
//
// Ports
//   i_clk     clock; all state changes on the rising edge
//   i_srst    synchronous reset, active-high; overrides every other input
//   i_src     set sources; channel c, source s is bit c*SOURCES+s
//   i_clr     per-channel clear strobe
//   i_mask    per-channel interrupt enable (1 = enabled)
//   o_flags   sticky flags
//   o_ovf     sticky overflow: a set event arrived while the flag was already set
//   o_count   saturating set-event count; channel c at [c*COUNT_W +: COUNT_W]
//   o_irq     registered OR of (flags & mask)
//
// Parameters
//   CHANNELS      number of independent channels (>=1)
//   SOURCES       set sources OR-ed per channel (>=1)
//   SET_PRIORITY  on simultaneous set and clear: 1 = set wins, 0 = clear wins
//   EDGE_MODE     0 = level-sensitive set, 1 = set on a rising source edge only
//   COUNT_W       width of each event counter (>=1)

module set_clear_flags #(
   parameter int CHANNELS     = 8,
   parameter int SOURCES      = 2,
   parameter int SET_PRIORITY = 1,
   parameter int EDGE_MODE    = 0,
   parameter int COUNT_W      = 4
) (
   input  logic                          i_clk,
   input  logic                          i_srst,
   input  logic [CHANNELS*SOURCES-1:0]   i_src,
   input  logic [CHANNELS-1:0]           i_clr,
   input  logic [CHANNELS-1:0]           i_mask,
   output logic [CHANNELS-1:0]           o_flags,
   output logic [CHANNELS-1:0]           o_ovf,
   output logic [CHANNELS*COUNT_W-1:0]   o_count,
   output logic                          o_irq
);

   localparam int                NSRC     = CHANNELS * SOURCES;
   localparam logic              EDGE     = (EDGE_MODE != 0);
   localparam logic              SET_WINS = (SET_PRIORITY != 0);
   localparam logic [COUNT_W-1:0] CNT_MAX = '1;
   localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

   logic [NSRC-1:0]             src_hist_q;
   logic [CHANNELS-1:0]         flags_q, flags_d;
   logic [CHANNELS-1:0]         ovf_q, ovf_d;
   logic [CHANNELS*COUNT_W-1:0] count_q, count_d;
   logic                        irq_q, irq_d;

   logic [NSRC-1:0]             hist_eff;
   logic [NSRC-1:0]             src_evt;
   logic [CHANNELS-1:0]         set_req;

   // In level mode the history is forced to zero so a high source is an event
   // every cycle; in edge mode only a 0->1 transition is.
   assign hist_eff = src_hist_q & {NSRC{EDGE}};
   assign src_evt  = i_src & ~hist_eff;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_set
      assign set_req[c] = |src_evt[c*SOURCES +: SOURCES];
   end

   always_comb begin
      flags_d = flags_q;
      ovf_d   = ovf_q;
      count_d = count_q;
      for (int c = 0; c < CHANNELS; c++) begin
         unique case ({i_clr[c], set_req[c]})
            2'b01: begin
               flags_d[c] = 1'b1;
               ovf_d[c]   = ovf_q[c] | flags_q[c];
               if (count_q[c*COUNT_W +: COUNT_W] != CNT_MAX) begin
                  count_d[c*COUNT_W +: COUNT_W] = count_q[c*COUNT_W +: COUNT_W] + CNT_ONE;
               end
            end
            2'b10: begin
               flags_d[c]                    = 1'b0;
               ovf_d[c]                      = 1'b0;
               count_d[c*COUNT_W +: COUNT_W] = '0;
            end
            2'b11: begin
               // Set-wins behaves as clear followed by a fresh first event.
               flags_d[c]                    = SET_WINS;
               ovf_d[c]                      = 1'b0;
               count_d[c*COUNT_W +: COUNT_W] = SET_WINS ? CNT_ONE : '0;
            end
            default: begin
            end
         endcase
      end
      // Interrupt follows the next flag value so it moves on the same edge.
      irq_d = |(flags_d & i_mask);
   end

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         src_hist_q <= '0;
         flags_q    <= '0;
         ovf_q      <= '0;
         count_q    <= '0;
         irq_q      <= 1'b0;
      end else begin
         src_hist_q <= i_src;
         flags_q    <= flags_d;
         ovf_q      <= ovf_d;
         count_q    <= count_d;
         irq_q      <= irq_d;
      end
   end

   assign o_flags = flags_q;
   assign o_ovf   = ovf_q;
   assign o_count = count_q;
   assign o_irq   = irq_q;

endmodule

// File: tb/tb_set_clear_flags.sv
module tb_set_clear_flags;

   logic clk;
   logic srst;

   // level mode, set wins
   logic [7:0]  src_a;
   logic [3:0]  clr_a, mask_a, flags_a, ovf_a;
   logic [11:0] count_a;
   logic        irq_a;
   // edge mode, set wins
   logic [7:0]  src_b;
   logic [3:0]  clr_b, mask_b, flags_b, ovf_b;
   logic [11:0] count_b;
   logic        irq_b;
   // level mode, clear wins
   logic [7:0]  src_c;
   logic [3:0]  clr_c, mask_c, flags_c, ovf_c;
   logic [11:0] count_c;
   logic        irq_c;

   int total = 0;
   int bad   = 0;

   set_clear_flags #(.CHANNELS(4), .SOURCES(2), .SET_PRIORITY(1), .EDGE_MODE(0), .COUNT_W(3)) u_lvl (
      .i_clk(clk), .i_srst(srst), .i_src(src_a), .i_clr(clr_a), .i_mask(mask_a),
      .o_flags(flags_a), .o_ovf(ovf_a), .o_count(count_a), .o_irq(irq_a));

   set_clear_flags #(.CHANNELS(4), .SOURCES(2), .SET_PRIORITY(1), .EDGE_MODE(1), .COUNT_W(3)) u_edg (
      .i_clk(clk), .i_srst(srst), .i_src(src_b), .i_clr(clr_b), .i_mask(mask_b),
      .o_flags(flags_b), .o_ovf(ovf_b), .o_count(count_b), .o_irq(irq_b));

   set_clear_flags #(.CHANNELS(4), .SOURCES(2), .SET_PRIORITY(0), .EDGE_MODE(0), .COUNT_W(3)) u_sp0 (
      .i_clk(clk), .i_srst(srst), .i_src(src_c), .i_clr(clr_c), .i_mask(mask_c),
      .o_flags(flags_c), .o_ovf(ovf_c), .o_count(count_c), .o_irq(irq_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      srst  = 1'b1;
      src_a = '0; clr_a = '0; mask_a = '0;
      src_b = '0; clr_b = '0; mask_b = '0;
      src_c = '0; clr_c = '0; mask_c = '0;
      tick();
      tick();
      srst = 1'b0;

      // reset state
      chk("rst_flags", 32'(flags_a), 'h0);
      chk("rst_ovf",   32'(ovf_a),   'h0);
      chk("rst_count", 32'(count_a), 'h0);
      chk("rst_irq",   32'(irq_a),   'h0);
      chk("rst_flags_edg", 32'(flags_b), 'h0);

      // 1: one-cycle pulse on ch1 src1
      mask_a = 4'b0010;
      src_a  = 8'b0000_1000;
      tick();
      chk("t1_flags", 32'(flags_a), 'h2);
      chk("t1_count", 32'(count_a), 'h008);
      chk("t1_irq",   32'(irq_a),   'h1);
      chk("t1_ovf",   32'(ovf_a),   'h0);
      src_a = '0;
      tick();
      tick();
      chk("t1_hold_flags", 32'(flags_a), 'h2);
      chk("t1_hold_count", 32'(count_a), 'h008);
      chk("t1_hold_irq",   32'(irq_a),   'h1);
      clr_a = 4'b0010;
      tick();
      clr_a = '0;
      chk("t1_clr_flags", 32'(flags_a), 'h0);
      chk("t1_clr_count", 32'(count_a), 'h0);
      chk("t1_clr_irq",   32'(irq_a),   'h0);

      // 2: level source held on ch0, counter saturates at 7
      mask_a = '0;
      src_a  = 8'b0000_0001;
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk("t2_count", 32'(count_a[2:0]), (i < 7) ? i : 7);
         chk("t2_ovf",   32'(ovf_a[0]),     (i >= 2) ? 1 : 0);
      end
      chk("t2_other_ch", 32'(count_a[11:3]), 'h0);
      src_a = '0;
      clr_a = 4'b0001;
      tick();
      clr_a = '0;
      chk("t2_clr_flags", 32'(flags_a), 'h0);
      chk("t2_clr_ovf",   32'(ovf_a),   'h0);
      chk("t2_clr_count", 32'(count_a), 'h0);

      // 4: simultaneous set and clear with flag=1, ovf=1, count=5
      src_a = 8'b0000_0001;
      src_c = 8'b0000_0010;  // ch0 src1
      for (int i = 0; i < 5; i++) tick();
      chk("t4_pre_count_sp1", 32'(count_a[2:0]), 5);
      chk("t4_pre_ovf_sp1",   32'(ovf_a[0]),     1);
      chk("t4_pre_count_sp0", 32'(count_c[2:0]), 5);
      chk("t4_pre_ovf_sp0",   32'(ovf_c[0]),     1);
      clr_a = 4'b0001;
      clr_c = 4'b0001;
      tick();
      chk("t4_sp1_flags", 32'(flags_a), 'h1);
      chk("t4_sp1_ovf",   32'(ovf_a),   'h0);
      chk("t4_sp1_count", 32'(count_a), 'h001);
      chk("t4_sp0_flags", 32'(flags_c), 'h0);
      chk("t4_sp0_ovf",   32'(ovf_c),   'h0);
      chk("t4_sp0_count", 32'(count_c), 'h0);
      clr_a = '0; clr_c = '0;
      src_a = '0; src_c = '0;

      // 5: set all flags with full mask, then mask off
      clr_a = 4'b1111;
      tick();
      clr_a  = '0;
      src_a  = 8'b0101_0101;
      mask_a = 4'b1111;
      tick();
      chk("t5_flags", 32'(flags_a), 'hF);
      chk("t5_irq",   32'(irq_a),   'h1);
      src_a  = '0;
      mask_a = 4'b0000;
      tick();
      chk("t5_mask_irq",   32'(irq_a),   'h0);
      chk("t5_mask_flags", 32'(flags_a), 'hF);
      mask_a = 4'b1000;
      tick();
      chk("t5_unmask_irq", 32'(irq_a), 'h1);

      // 3: edge mode, ch2 src0 held high
      src_b = 8'b0001_0000;
      tick();
      chk("t3_first_count", 32'(count_b[8:6]), 1);
      for (int i = 0; i < 4; i++) tick();
      chk("t3_held_count", 32'(count_b[8:6]), 1);
      chk("t3_held_ovf",   32'(ovf_b[2]),     0);
      chk("t3_held_flags", 32'(flags_b),      'h4);
      src_b = '0;
      tick();
      chk("t3_low_count", 32'(count_b[8:6]), 1);
      src_b = 8'b0001_0000;
      tick();
      chk("t3_rise_count", 32'(count_b[8:6]), 2);
      chk("t3_rise_ovf",   32'(ovf_b[2]),     1);

      // 6: reset mid-burst with active sources and clears
      src_a  = 8'hFF;
      clr_a  = 4'b0001;
      mask_a = 4'b1111;
      src_b  = 8'b0000_0001;
      mask_b = 4'b1111;
      srst   = 1'b1;
      tick();
      chk("t6_rst_flags_a", 32'(flags_a), 'h0);
      chk("t6_rst_ovf_a",   32'(ovf_a),   'h0);
      chk("t6_rst_count_a", 32'(count_a), 'h0);
      chk("t6_rst_irq_a",   32'(irq_a),   'h0);
      chk("t6_rst_flags_b", 32'(flags_b), 'h0);
      chk("t6_rst_count_b", 32'(count_b), 'h0);
      srst  = 1'b0;
      clr_a = '0;
      tick();
      chk("t6_post_flags_b", 32'(flags_b), 'h1);
      chk("t6_post_count_b", 32'(count_b), 'h001);
      chk("t6_post_irq_b",   32'(irq_b),   'h1);
      chk("t6_post_flags_a", 32'(flags_a), 'hF);
      chk("t6_post_count_a", 32'(count_a), 'h249);
      tick();
      chk("t6_held_count_b", 32'(count_b), 'h001);
      chk("t6_held_ovf_b",   32'(ovf_b),   'h0);
      chk("t6_held_ovf_a",   32'(ovf_a),   'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
